// File: rtl/bus_pkg.sv
// Shared definitions for the 16-bit addr/data/rw/valid register daisy chain:
// bus widths, initiator FSM states and the chain beat record.
package bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } bus_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              rw;
      logic              valid;
   } bus_txn;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for the initiator WAIT state; expired is raised on the
// cycle where the count reaches limit-1.
module bus_timeout_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   // Holds at the expiry value so an unattended enable never wraps around.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign expired = (count_q == (limit - 1'b1));

endmodule

// File: rtl/bus_initiator.sv
// Chain-head initiator: issues one host request as a single bus beat, waits for
// it at the chain tail, answers over valid/ready. Optional BUS_INITIATOR_STATS_EN.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_data_i,
   input  logic              req_rw_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              rw_o,
   output logic              valid_o,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rw_i,
   input  logic              valid_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_data_o,
   output logic              resp_err_o
`ifdef BUS_INITIATOR_STATS_EN
   ,
   output logic [15:0]       txn_count_o,
   output logic [15:0]       timeout_count_o
`endif
);

   bus_state_e        state_q, state_d;
   bus_txn            head_q, head_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_data_q, resp_data_d;
   logic              resp_err_q, resp_err_d;
   logic              cnt_clear, cnt_en, cnt_expired;
   logic              ret_match;

   bus_timeout_counter #(
      .CNT_W (16)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .limit   (16'(TIMEOUT_CYCLES)),
      .expired (cnt_expired)
   );

   // Only a beat carrying our own address and direction is our returning transaction.
   assign ret_match = valid_i && (addr_i == head_q.addr) && (rw_i == head_q.rw);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         head_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      head_d.valid = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               head_d.addr  = req_addr_i;
               head_d.data  = req_data_i;
               head_d.rw    = req_rw_i;
               head_d.valid = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_clear = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            cnt_en = 1'b1;
            // A return arriving on the expiry cycle still wins over the timeout.
            if (ret_match) begin
               resp_data_d  = data_i;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else if (cnt_expired) begin
               resp_data_d  = '0;
               resp_err_d   = 1'b1;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready_o  = (state_q == IDLE);
   assign addr_o       = head_q.addr;
   assign data_o       = head_q.data;
   assign rw_o         = head_q.rw;
   assign valid_o      = head_q.valid;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_err_o   = resp_err_q;

`ifdef BUS_INITIATOR_STATS_EN
   logic [15:0] txn_cnt_q, to_cnt_q;
   logic        resp_hs;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign resp_hs = (state_q == RESP) && resp_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         txn_cnt_q <= '0;
         to_cnt_q  <= '0;
      end else if (resp_hs) begin
         txn_cnt_q <= sat_inc16(txn_cnt_q);
         if (resp_err_q) begin
            to_cnt_q <= sat_inc16(to_cnt_q);
         end
      end
   end

   assign txn_count_o     = txn_cnt_q;
   assign timeout_count_o = to_cnt_q;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboarded bench for bus_initiator: a 3-register loopback chain with a
// small core model feeds returns; a monitor compares responses to predictions.
`timescale 1ns/1ps
module tb_bus_initiator;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o, req_rw_i;
   logic [15:0] req_addr_i, req_data_i;
   logic [15:0] addr_o, data_o, addr_i, data_i;
   logic        rw_o, valid_o, rw_i, valid_i;
   logic        resp_valid_o, resp_ready_i, resp_err_o;
   logic [15:0] resp_data_o;
`ifdef BUS_INITIATOR_STATS_EN
   logic [15:0] txn_count_o, timeout_count_o;
`endif

   always #5 clk = ~clk;

   bus_initiator #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_data_i   (req_data_i),
      .req_rw_i     (req_rw_i),
      .addr_o       (addr_o),
      .data_o       (data_o),
      .rw_o         (rw_o),
      .valid_o      (valid_o),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .rw_i         (rw_i),
      .valid_i      (valid_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .resp_err_o   (resp_err_o)
`ifdef BUS_INITIATOR_STATS_EN
      ,
      .txn_count_o     (txn_count_o),
      .timeout_count_o (timeout_count_o)
`endif
   );

   // Chain contents: a read of any never-written address returns this value.
   function automatic logic [15:0] dflt(input logic [15:0] a);
      if (a == 16'h0012) return 16'hBEEF;
      return (a * 16'h003B) ^ 16'h5A00;
   endfunction

   // ---------------- 3-register loopback chain with one core at stage 1
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic        rw;
      logic        v;
   } beat_t;

   beat_t       s0 = '0, s1 = '0, s2 = '0;
   logic [15:0] core_mem [256];
   bit          core_wr  [256];
   int          beat_cnt = 0;
   bit          drop = 1'b0;
   bit          stray_en = 1'b0;
   logic [15:0] stray_addr = '0;
   logic        stray_rw = 1'b0;

   always @(posedge clk) begin
      if (valid_o) beat_cnt <= beat_cnt + 1;
      s0 <= '{a: addr_o, d: data_o, rw: rw_o, v: valid_o && !drop};
      s1 <= s0;
      if (s0.v && !s0.rw)
         s1.d <= core_wr[s0.a[7:0]] ? core_mem[s0.a[7:0]] : dflt(s0.a);
      if (s0.v && s0.rw) begin
         core_mem[s0.a[7:0]] <= s0.d;
         core_wr[s0.a[7:0]]  <= 1'b1;
      end
      s2 <= s1;
   end

   assign addr_i  = stray_en ? stray_addr : s2.a;
   assign data_i  = stray_en ? 16'hDEAD : s2.d;
   assign rw_i    = stray_en ? stray_rw : s2.rw;
   assign valid_i = stray_en | s2.v;

   // ---------------- checking
   int total = 0;
   int passed = 0;
   logic [16:0] sb [$];
   logic [15:0] ref_mem [logic [15:0]];
   int model_txn = 0;
   int model_to = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      #2;
      if (!rst && resp_valid_o) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", {31'd0, resp_valid_o}, 32'd0);
         end else begin
            chk("resp_data", {16'd0, resp_data_o}, {16'd0, sb[0][15:0]});
            chk("resp_err", {31'd0, resp_err_o}, {31'd0, sb[0][16]});
            if (resp_ready_i) void'(sb.pop_front());
         end
      end
   end

   // ---------------- stimulus
   task automatic run_txn(input logic [15:0] a, input logic [15:0] d, input logic rw,
                          input bit drop_it, input bit stray, input logic [15:0] stray_a,
                          input int hold);
      int          k;
      int          beats0;
      logic [15:0] exp_d;
      k = 0;
      while (!req_ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);

      if (drop_it) exp_d = '0;
      else if (rw) begin
         exp_d = d;
         ref_mem[a] = d;
      end else exp_d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      sb.push_back({drop_it, exp_d});
      model_txn++;
      if (drop_it) model_to++;

      beats0 = beat_cnt;
      drop = drop_it;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_data_i  = d;
      req_rw_i    = rw;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      req_addr_i  = 16'($urandom);
      req_data_i  = 16'($urandom);
      chk("valid_o_issue", {31'd0, valid_o}, 32'd1);
      chk("addr_o", {16'd0, addr_o}, {16'd0, a});
      chk("data_o", {16'd0, data_o}, {16'd0, d});
      chk("rw_o", {31'd0, rw_o}, {31'd0, rw});
      chk("req_ready_issue", {31'd0, req_ready_o}, 32'd0);
      @(negedge clk);
      chk("valid_o_pulse", {31'd0, valid_o}, 32'd0);
      chk("addr_o_hold", {16'd0, addr_o}, {16'd0, a});
      if (stray) begin
         stray_addr = stray_a;
         stray_rw   = rw;
         stray_en   = 1'b1;
      end
      @(negedge clk);
      stray_en = 1'b0;
      k = 2;
      while (!resp_valid_o && k < TO + 20) begin
         chk("req_ready_wait", {31'd0, req_ready_o}, 32'd0);
         @(negedge clk);
         k++;
      end
      chk("resp_latency", k, drop_it ? TO + 1 : 4);
      chk("chain_beats", beat_cnt - beats0, 1);

      // Response held back: host keeps requesting, initiator must not take it.
      for (int i = 0; i < hold; i++) begin
         req_valid_i = 1'b1;
         chk("req_ready_resp", {31'd0, req_ready_o}, 32'd0);
         chk("resp_valid_hold", {31'd0, resp_valid_o}, 32'd1);
         chk("no_issue_in_resp", {31'd0, valid_o}, 32'd0);
         @(negedge clk);
      end
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready_i = 1'b0;
      drop = 1'b0;
      chk("resp_valid_drop", {31'd0, resp_valid_o}, 32'd0);
      chk("req_ready_after", {31'd0, req_ready_o}, 32'd1);
   endtask

   task automatic reset_mid();
      req_valid_i = 1'b1;
      req_addr_i  = 16'h0012;
      req_data_i  = 16'h0000;
      req_rw_i    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      model_txn = 0;
      model_to  = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_addr_o", {16'd0, addr_o}, 32'd0);
      chk("rst_data_o", {16'd0, data_o}, 32'd0);
      chk("rst_rw_o", {31'd0, rw_o}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
      chk("rst_resp_data", {16'd0, resp_data_o}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("late_return_ignored", {31'd0, resp_valid_o}, 32'd0);
         chk("late_no_issue", {31'd0, valid_o}, 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      rst          = 1'b1;
      req_valid_i  = 1'b0;
      req_addr_i   = '0;
      req_data_i   = '0;
      req_rw_i     = 1'b0;
      resp_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("init_valid_o", {31'd0, valid_o}, 32'd0);
      chk("init_addr_o", {16'd0, addr_o}, 32'd0);
      chk("init_resp_valid", {31'd0, resp_valid_o}, 32'd0);
      chk("init_resp_err", {31'd0, resp_err_o}, 32'd0);
      chk("init_resp_data", {16'd0, resp_data_o}, 32'd0);
      @(negedge clk);
      chk("init_req_ready", {31'd0, req_ready_o}, 32'd1);

      run_txn(16'h0012, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
      run_txn(16'h0004, 16'h00A5, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
      run_txn(16'h0030, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 2);
      run_txn(16'h0012, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0099, 0);
      run_txn(16'h0004, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000, 5);
      reset_mid();

      for (int n = 0; n < 40; n++) begin
         a = 16'($urandom_range(0, 255));
         run_txn(a, 16'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 a ^ 16'h0100, $urandom_range(0, 4));
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
`ifdef BUS_INITIATOR_STATS_EN
      chk("txn_count", {16'd0, txn_count_o}, model_txn);
      chk("timeout_count", {16'd0, timeout_count_o}, model_to);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Originating end of the 16-bit addr/data/rw/valid register daisy chain. Converts one host request at a time (from the bridge/command decoder) into a single bus transaction at the chain head.
- Waits for that transaction to return at the chain tail, carrying read data filled in by the addressed core.
- Returns data, or a timeout error, to the host over a valid/ready response handshake.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in WAIT before declaring a timeout; legal range 1..65535.
- ADDR_W, 16: bus address width; fixed by the chain.
- DATA_W, 16: bus data width; fixed by the chain.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  host request valid
- req_ready_o  out  1  initiator can accept a request
- req_addr_i  in  16  request address
- req_data_i  in  16  write data; ignored for reads
- req_rw_i  in  1  1 = write, 0 = read
- addr_o  out  16  chain-head address
- data_o  out  16  chain-head data
- rw_o  out  1  chain-head rw
- valid_o  out  1  chain-head valid
- addr_i  in  16  chain-tail returned address
- data_i  in  16  chain-tail returned data
- rw_i  in  1  chain-tail returned rw
- valid_i  in  1  chain-tail returned valid
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  host accepts response
- resp_data_o  out  16  read data; echoed write data for writes
- resp_err_o  out  1  1 = transaction timed out

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports clk and rst.
- Reset values: state = IDLE; addr_o, data_o, rw_o, valid_o, resp_valid_o, resp_data_o, resp_err_o = 0; timeout counter = 0; req_ready_o = 1 the cycle after reset deasserts.
- FSM IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o: latch addr, data and rw into addr_o, data_o and rw_o; set valid_o = 1; go to ISSUE.
- FSM ISSUE:
  - valid_o is high for exactly this one cycle. It deasserts next cycle; addr_o, data_o and rw_o hold their values.
  - Go to WAIT and clear the counter.
- FSM WAIT:
  - Match condition: valid_i & (addr_i == addr_o) & (rw_i == rw_o).
  - On match: capture data_i into resp_data_o, set resp_err_o = 0, resp_valid_o = 1, go to RESP.
  - Non-matching valid_i beats are stray and are ignored.
  - Counter increments each WAIT cycle. When counter == TIMEOUT_CYCLES-1 with no match, set resp_data_o = 0, resp_err_o = 1, resp_valid_o = 1, go to RESP.
  - A match and a timeout in the same cycle resolve as a match.
- FSM RESP:
  - resp_valid_o and resp_data_o/resp_err_o stay stable until resp_ready_i.
  - On resp_ready_i, deassert resp_valid_o next cycle and go to IDLE.
  - valid_i is ignored in RESP and IDLE.
- req_ready_o = 1 only in IDLE; combinational from state.
- Latency:
  - Request accepted at cycle N → valid_o high at N+1.
  - Return seen at cycle M → resp_valid_o high at M+1.
  - Zero-latency chain loopback (valid_i same cycle as valid_o) is not a match, because matching starts in WAIT; minimum chain depth is 1 register.
- Back-to-back: earliest next acceptance is the cycle after the response handshake.
- rst mid-transaction: abandon immediately, all outputs return to reset values; a late return after reset is ignored in IDLE.

Optional Feature:
- Macro: BUS_INITIATOR_STATS_EN.
- Defined:
  - Adds outputs txn_count_o[15:0] and timeout_count_o[15:0].
  - txn_count_o increments on each response handshake; timeout_count_o increments when a handshake has resp_err_o = 1.
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package bus_pkg holds: ADDR_W/DATA_W constants, the FSM state enum (IDLE, ISSUE, WAIT, RESP), and a bus_txn struct {addr, data, rw, valid}.
- One natural sub-module: bus_timeout_counter (clear, enable, limit, expired flag). All else stays inline.

Test Plan:
- Read via 3-register loopback chain where the model fills data 16'hBEEF at addr 16'h0012: req_addr 16'h0012, rw 0 → valid_o pulses once at N+1; resp_valid, resp_data 16'hBEEF, resp_err 0 at return+1.
- Write addr 16'h0004 data 16'h00A5 → chain receives exactly one valid beat with rw 1; response has data 16'h00A5, err 0.
- TIMEOUT_CYCLES=8 with chain returning nothing → resp_err 1, resp_data 0, resp_valid exactly 8 cycles after entering WAIT; req_ready low throughout.
- Stray valid_i with addr 16'h0099 during WAIT for 16'h0012, followed by the correct return → stray ignored, response carries the correct data.
- Hold resp_ready_i low for 5 cycles → response stays stable; a new req_valid is not accepted until 1 cycle after ready. Assert rst during WAIT → all outputs 0, and a subsequent return produces no response.
- STATS_EN: 3 good transactions + 1 timeout → txn_count 4, timeout_count 1; force 65536 transactions → txn_count saturates at 16'hFFFF.
